// File: rtl/signed_add_overflow_pipe.sv
// signed_add_overflow_pipe
// Pipelined two's-complement adder. Each stage adds one CHUNK-bit slice and
// passes its carry on. Unconsumed operand slices ride in skew registers and
// finished result slices ride in deskew registers. The last stage detects
// overflow, optionally saturates, and drives the registered outputs. A sticky
// saturating counter tracks how many results overflowed.

module signed_add_overflow_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             saturate,
  input  logic             clr_count,
  output logic             down_valid,
  output logic [WIDTH-1:0] sum,
  output logic             overflow,
  output logic [CNT_W-1:0] overflow_count
);

  localparam int STAGES = WIDTH / CHUNK;

  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             dv_q;
  logic             ovf_q;
  logic [WIDTH-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // OW: operand bits still to be added at this stage (this slice and above).
    // RW: result bits known once this stage has added its slice.
    localparam int OW = WIDTH - k * CHUNK;
    localparam int RW = (k + 1) * CHUNK;

    logic [OW-1:0]  a_in;
    logic [OW-1:0]  b_in;
    logic           c_in;
    logic           v_in;
    logic           s_in;
    logic [CHUNK:0] csum;
    logic [RW-1:0]  r_full;

    if (k == 0) begin : g_src
      assign a_in   = a;
      assign b_in   = b;
      assign c_in   = 1'b0;
      assign v_in   = up_valid;
      assign s_in   = saturate;
      assign r_full = csum[CHUNK-1:0];
    end else begin : g_src
      assign a_in   = g_stage[k-1].g_reg.a_q;
      assign b_in   = g_stage[k-1].g_reg.b_q;
      assign c_in   = g_stage[k-1].g_reg.c_q;
      assign v_in   = g_stage[k-1].g_reg.v_q;
      assign s_in   = g_stage[k-1].g_reg.s_q;
      assign r_full = {csum[CHUNK-1:0], g_stage[k-1].g_reg.r_q};
    end

    // Slice adder: the extra top bit is the carry out of this slice.
    assign csum = {1'b0, a_in[CHUNK-1:0]} + {1'b0, b_in[CHUNK-1:0]}
                + {{CHUNK{1'b0}}, c_in};

    if (k < STAGES - 1) begin : g_reg
      logic [OW-CHUNK-1:0] a_q;
      logic [OW-CHUNK-1:0] b_q;
      logic [RW-1:0]       r_q;
      logic                c_q;
      logic                v_q;
      logic                s_q;

      // Stage valid: cleared by reset so in-flight work is discarded.
      // NOTE: sequential state is always assigned with <= so every register
      // samples the pre-edge values of its neighbours.
      always_ff @(posedge clk) begin
        if (rst) v_q <= 1'b0;
        else     v_q <= v_in;
      end

      // Stage payload: skew, deskew, carry and mode, loaded only with valid data.
      // NOTE: payload registers carry no reset; nothing downstream uses them
      // unless the matching valid bit is set.
      always_ff @(posedge clk) begin
        if (v_in) begin
          a_q <= a_in[OW-1:CHUNK];
          b_q <= b_in[OW-1:CHUNK];
          r_q <= r_full;
          c_q <= csum[CHUNK];
          s_q <= s_in;
        end
      end
    end else begin : g_out
      logic msb_carry_in;
      logic ovf_next;

      // Carry into the sign bit is recovered from the sign-bit sum itself.
      assign msb_carry_in = a_in[CHUNK-1] ^ b_in[CHUNK-1] ^ csum[CHUNK-1];
      assign ovf_next     = msb_carry_in ^ csum[CHUNK];

      // Output stage: overflow, optional clamp, and hold while idle.
      always_ff @(posedge clk) begin
        if (rst) begin
          dv_q  <= 1'b0;
          sum_q <= '0;
          ovf_q <= 1'b0;
        end else begin
          dv_q <= v_in;
          if (v_in) begin
            ovf_q <= ovf_next;
            if (s_in && ovf_next) sum_q <= a_in[CHUNK-1] ? MIN_NEG : MAX_POS;
            else                  sum_q <= r_full;
          end
        end
      end
    end
  end

  // Overflow event counter: clear wins, then saturating increment.
  always_ff @(posedge clk) begin
    if (rst || clr_count) begin
      cnt_q <= '0;
    end else if (dv_q && ovf_q && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign down_valid     = dv_q;
  assign sum            = sum_q;
  assign overflow       = ovf_q;
  assign overflow_count = cnt_q;

endmodule

// File: tb/tb_signed_add_overflow_pipe.sv
// Testbench for signed_add_overflow_pipe: directed vectors on the default
// 16/4 configuration, the 4/4 single-stage configuration and a 2-bit counter
// instance, plus a random valid-gated stream against a reference model.

module tb_signed_add_overflow_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_valid;
  logic        saturate;
  logic        clr_count;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  a4;
  logic [3:0]  b4;

  logic        down_valid;
  logic        overflow;
  logic [15:0] sum;
  logic [7:0]  overflow_count;

  logic        dv4;
  logic        ovf4;
  logic [3:0]  sum4;
  logic [7:0]  cnt4;

  logic        dvc;
  logic        ovfc;
  logic [15:0] sumc;
  logic [1:0]  cntc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  signed_add_overflow_pipe #(.WIDTH(16), .CHUNK(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .up_valid(up_valid), .a(a), .b(b),
    .saturate(saturate), .clr_count(clr_count), .down_valid(down_valid),
    .sum(sum), .overflow(overflow), .overflow_count(overflow_count)
  );

  signed_add_overflow_pipe #(.WIDTH(4), .CHUNK(4), .CNT_W(8)) dut_w4 (
    .clk(clk), .rst(rst), .up_valid(up_valid), .a(a4), .b(b4),
    .saturate(saturate), .clr_count(clr_count), .down_valid(dv4),
    .sum(sum4), .overflow(ovf4), .overflow_count(cnt4)
  );

  signed_add_overflow_pipe #(.WIDTH(16), .CHUNK(4), .CNT_W(2)) dut_cnt (
    .clk(clk), .rst(rst), .up_valid(up_valid), .a(a), .b(b),
    .saturate(saturate), .clr_count(clr_count), .down_valid(dvc),
    .sum(sumc), .overflow(ovfc), .overflow_count(cntc)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer sum, range test, clamp by direction of overflow.
  function automatic logic [16:0] model(input int w, input int av, input int bv, input bit sat);
    int t, mx, mn, r;
    bit o;
    t  = av + bv;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    o  = (t > mx) || (t < mn);
    r  = (sat && o) ? ((t > mx) ? mx : mn) : t;
    return {o, 16'(r & ((1 << w) - 1))};
  endfunction

  // One transaction on the 16-bit pipe; result must appear exactly 4 cycles on.
  task automatic run_one(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic sat, input logic [15:0] es, input logic eo);
    @(posedge clk); #1;
    up_valid = 1'b1; a = av; b = bv; saturate = sat;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) up_valid = 1'b0;
      if (c < 4) begin
        check({tag, "_early"}, 32'(down_valid), 32'(0));
      end else begin
        check({tag, "_dv"},  32'(down_valid), 32'(1));
        check({tag, "_sum"}, 32'(sum),        32'(es));
        check({tag, "_ovf"}, 32'(overflow),   32'(eo));
      end
    end
  endtask

  // One transaction on the single-stage 4-bit pipe; latency 1.
  task automatic run_w4(input string tag, input logic [3:0] av, input logic [3:0] bv,
                        input logic [3:0] es, input logic eo);
    @(posedge clk); #1;
    up_valid = 1'b1; a4 = av; b4 = bv; saturate = 1'b0;
    @(posedge clk); #1;
    up_valid = 1'b0;
    check({tag, "_dv"},  32'(dv4),  32'(1));
    check({tag, "_sum"}, 32'(sum4), 32'(es));
    check({tag, "_ovf"}, 32'(ovf4), 32'(eo));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      up_valid  = 1'b0;
      clr_count = 1'b0;
    end
  endtask

  logic [16:0] q16[$];
  logic [16:0] q4[$];
  bit          uvlog[1004];
  logic [16:0] e;

  initial begin
    rst = 1'b1; up_valid = 1'b0; saturate = 1'b0; clr_count = 1'b0;
    a = '0; b = '0; a4 = '0; b4 = '0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_dv",   32'(down_valid),     32'(0));
    check("rst_sum",  32'(sum),            32'(0));
    check("rst_ovf",  32'(overflow),       32'(0));
    check("rst_cnt",  32'(overflow_count), 32'(0));
    check("rst_cnt4", 32'(cnt4),           32'(0));
    check("rst_sumc", 32'(sumc),           32'(0));
    rst = 1'b0;
    idle(2);

    // Directed vectors, 16-bit / 4-bit chunks
    run_one("pos_wrap",  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
    run_one("pos_sat",   16'h7FFF, 16'h0001, 1'b1, 16'h7FFF, 1'b1);
    run_one("neg_wrap",  16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1);
    run_one("neg_sat",   16'h8000, 16'hFFFF, 1'b1, 16'h8000, 1'b1);
    run_one("min_min",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    run_one("xchunk",    16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0);
    run_one("m1_p1",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0);
    run_one("m1_p1_sat", 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0);
    run_one("half_half", 16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b1);

    // Output holds while idle
    @(posedge clk); #1;
    check("hold_dv",  32'(down_valid), 32'(0));
    check("hold_sum", 32'(sum),        32'(16'h8000));
    check("hold_ovf", 32'(overflow),   32'(1));

    // Single-stage 4-bit configuration
    run_w4("w4_4p7",   4'h4, 4'h7, 4'hB, 1'b1);
    run_w4("w4_m4m4",  4'hC, 4'hC, 4'h8, 1'b0);
    idle(6);

    // Random stream with random valid gaps and random mode
    for (int j = 0; j < 1004; j++) begin
      @(posedge clk); #1;
      check("stream_dv",  32'(down_valid), 32'((j >= 4) ? uvlog[j-4] : 1'b0));
      check("stream_dv4", 32'(dv4),        32'((j >= 1) ? uvlog[j-1] : 1'b0));
      if (down_valid) begin
        if (q16.size() == 0) begin
          check("stream_sb16_empty", 32'(1), 32'(0));
        end else begin
          e = q16.pop_front();
          check("stream_sum16", 32'(sum),      32'(e[15:0]));
          check("stream_ovf16", 32'(overflow), 32'(e[16]));
        end
      end
      if (dv4) begin
        if (q4.size() == 0) begin
          check("stream_sb4_empty", 32'(1), 32'(0));
        end else begin
          e = q4.pop_front();
          check("stream_sum4", 32'(sum4), 32'(e[3:0]));
          check("stream_ovf4", 32'(ovf4), 32'(e[16]));
        end
      end
      if (j < 1000) begin
        up_valid = ($urandom_range(0, 3) != 0);
        saturate = 1'($urandom_range(0, 1));
        a        = 16'($urandom);
        b        = 16'($urandom);
        a4       = 4'($urandom);
        b4       = 4'($urandom);
        uvlog[j] = up_valid;
        if (up_valid) begin
          q16.push_back(model(16, int'($signed(a)),  int'($signed(b)),  saturate));
          q4.push_back(model(4,   int'($signed(a4)), int'($signed(b4)), saturate));
        end
      end else begin
        up_valid = 1'b0;
        uvlog[j] = 1'b0;
      end
    end
    check("stream_sb16_drained", 32'(q16.size()), 32'(0));
    check("stream_sb4_drained",  32'(q4.size()),  32'(0));
    saturate = 1'b0;

    // Reset with three transactions in flight
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      check("rstmid_pre_dv", 32'(down_valid), 32'(0));
      up_valid = 1'b1; a = 16'h7FFF; b = 16'h0001;
    end
    @(posedge clk); #1;
    check("rstmid_pre_dv", 32'(down_valid), 32'(0));
    up_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_dv",  32'(down_valid),     32'(0));
    check("rstmid_sum", 32'(sum),            32'(0));
    check("rstmid_ovf", 32'(overflow),       32'(0));
    check("rstmid_cnt", 32'(overflow_count), 32'(0));
    up_valid = 1'b1; a = 16'd1; b = 16'd2;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) up_valid = 1'b0;
      if (c < 4) begin
        check("rstmid_ghost_dv", 32'(down_valid), 32'(0));
      end else begin
        check("after_rst_dv",  32'(down_valid), 32'(1));
        check("after_rst_sum", 32'(sum),        32'(3));
        check("after_rst_ovf", 32'(overflow),   32'(0));
      end
    end

    // Counter: saturation at 3 on the 2-bit instance
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("cnt_start", 32'(cntc), 32'(0));
    for (int j = 0; j < 5; j++) begin
      @(posedge clk); #1;
      up_valid = 1'b1; a = 16'h7FFF; b = 16'h0001;
    end
    idle(6);
    check("cnt_sat",  32'(cntc),           32'(3));
    check("cnt_wide", 32'(overflow_count), 32'(5));
    check("cnt_ovfc", 32'(ovfc),           32'(1));
    idle(3);
    check("cnt_hold", 32'(cntc), 32'(3));

    // Counter: clear coinciding with a counted overflow
    @(posedge clk); #1;
    up_valid = 1'b1; a = 16'h8000; b = 16'hFFFF;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) up_valid = 1'b0;
      if (c == 4) begin
        check("clr_align_dv", 32'(dvc), 32'(1));
        clr_count = 1'b1;
      end
    end
    @(posedge clk); #1;
    clr_count = 1'b0;
    check("clr_cnt",      32'(cntc),           32'(0));
    check("clr_cnt_wide", 32'(overflow_count), 32'(0));

    // Next overflow counts from zero
    @(posedge clk); #1;
    up_valid = 1'b1; a = 16'h4000; b = 16'h4000;
    idle(6);
    check("cnt_after_clr", 32'(cntc), 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
